// File: rtl/tx_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tx_byte_sequencer
//   Transmit bit-path controller. Accepts bytes over a valid/ready handshake
//   into a single holding register (which, together with the shift register,
//   double-buffers the stream), serializes each byte LSB-first with
//   CLKS_PER_BIT clocks per bit, and closes every packet with an end-of-packet
//   pattern: 2 bit periods low followed by 1 bit period high.
//
// Ports
//   i_clk         system clock, rising edge
//   i_n_rst       asynchronous active-low reset
//   i_tx_start    begin a packet (sampled only while idle)
//   i_abort       drop any transmission in progress, return to idle
//   i_byte_valid  upstream byte available
//   i_byte_data   byte to send
//   i_byte_last   final byte of the packet
//   o_byte_ready  byte accepted this cycle when i_byte_valid is also high
//   o_serial_out  serial line, idles high
//   o_bit_strobe  pulse on the last clock of every data bit period
//   o_tx_active   sequencer is not idle
//   o_tx_done     one-cycle pulse after the end-of-packet pattern completes
//   o_tx_error    sticky underrun flag, cleared by the next i_tx_start
// ---------------------------------------------------------------------------
module tx_byte_sequencer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       i_clk,
   input  logic       i_n_rst,
   input  logic       i_tx_start,
   input  logic       i_abort,
   input  logic       i_byte_valid,
   input  logic [7:0] i_byte_data,
   input  logic       i_byte_last,
   output logic       o_byte_ready,
   output logic       o_serial_out,
   output logic       o_bit_strobe,
   output logic       o_tx_active,
   output logic       o_tx_done,
   output logic       o_tx_error
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int EW = $clog2(3 * CLKS_PER_BIT);

   localparam logic [CW-1:0] CLK_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [EW-1:0] EOP_LOW = EW'(2 * CLKS_PER_BIT);
   localparam logic [EW-1:0] EOP_MAX = EW'(3 * CLKS_PER_BIT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_EOP   = 2'd3;

   logic [1:0]    r_state;
   logic [7:0]    r_hold_data;
   logic          r_hold_last;
   logic          r_hold_full;
   logic [7:0]    r_shift;
   logic          r_cur_last;
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_cnt;
   logic [EW-1:0] r_eop_cnt;
   logic          r_last_taken;
   logic          r_tx_done;
   logic          r_tx_error;

   logic w_byte_ready;
   logic w_accept;
   logic w_bit_end;
   logic w_serial;

   // Ready is a pure register decode, so there is no input-to-output path.
   // Once the last byte has been taken nothing more is accepted this packet.
   assign w_byte_ready = !r_hold_full && !r_last_taken &&
                         ((r_state == S_LOAD) || (r_state == S_SHIFT));
   assign w_accept     = i_byte_valid && w_byte_ready;
   assign w_bit_end    = (r_state == S_SHIFT) && (r_clk_cnt == CLK_MAX);

   always_comb begin
      w_serial = 1'b1;
      case (r_state)
         S_SHIFT: w_serial = r_shift[0];
         S_EOP:   w_serial = (r_eop_cnt >= EOP_LOW);
         default: w_serial = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_state      <= S_IDLE;
         r_hold_data  <= '0;
         r_hold_last  <= 1'b0;
         r_hold_full  <= 1'b0;
         r_shift      <= '0;
         r_cur_last   <= 1'b0;
         r_clk_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_eop_cnt    <= '0;
         r_last_taken <= 1'b0;
         r_tx_done    <= 1'b0;
         r_tx_error   <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         if (i_abort && (r_state != S_IDLE)) begin
            r_state      <= S_IDLE;
            r_hold_full  <= 1'b0;
            r_last_taken <= 1'b0;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_eop_cnt    <= '0;
         end else begin
            if (w_accept) begin
               r_hold_data <= i_byte_data;
               r_hold_last <= i_byte_last;
               r_hold_full <= 1'b1;
               if (i_byte_last)
                  r_last_taken <= 1'b1;
            end
            case (r_state)
               S_IDLE: begin
                  if (i_tx_start) begin
                     r_state      <= S_LOAD;
                     r_tx_error   <= 1'b0;
                     r_hold_full  <= 1'b0;
                     r_last_taken <= 1'b0;
                  end
               end
               S_LOAD: begin
                  // Accept and hold_full are exclusive here (ready needs an
                  // empty hold), so the hold_full clear cannot lose a byte.
                  if (r_hold_full) begin
                     r_shift     <= r_hold_data;
                     r_cur_last  <= r_hold_last;
                     r_hold_full <= 1'b0;
                     r_clk_cnt   <= '0;
                     r_bit_cnt   <= '0;
                     r_eop_cnt   <= '0;
                     r_state     <= S_SHIFT;
                  end
               end
               S_SHIFT: begin
                  if (w_bit_end) begin
                     r_clk_cnt <= '0;
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        if (r_cur_last) begin
                           r_state   <= S_EOP;
                           r_eop_cnt <= '0;
                        end else if (r_hold_full) begin
                           // Back-to-back reload: no idle gap between bytes.
                           r_shift     <= r_hold_data;
                           r_cur_last  <= r_hold_last;
                           r_hold_full <= 1'b0;
                           r_bit_cnt   <= '0;
                        end else begin
                           // Underrun: a byte arriving on this very edge is
                           // too late and is thrown away with the hold.
                           r_tx_error  <= 1'b1;
                           r_hold_full <= 1'b0;
                           r_state     <= S_EOP;
                           r_eop_cnt   <= '0;
                        end
                     end
                  end else begin
                     r_clk_cnt <= r_clk_cnt + CW'(1);
                  end
               end
               S_EOP: begin
                  if (r_eop_cnt == EOP_MAX) begin
                     r_state   <= S_IDLE;
                     r_eop_cnt <= '0;
                     r_tx_done <= 1'b1;
                  end else begin
                     r_eop_cnt <= r_eop_cnt + EW'(1);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_byte_ready = w_byte_ready;
   assign o_serial_out = w_serial;
   assign o_bit_strobe = w_bit_end;
   assign o_tx_active  = (r_state != S_IDLE);
   assign o_tx_done    = r_tx_done;
   assign o_tx_error   = r_tx_error;

endmodule

// File: tb/tb_tx_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tx_byte_sequencer
//   Scoreboard bench. The stimulus side pushes the bit sequence and the
//   end-of-packet outcome each packet should produce; an independent monitor
//   pops and compares on every bit strobe and every done pulse, and also
//   checks bit-period width, inter-bit spacing and the EOP low/high lengths.
// ---------------------------------------------------------------------------
module tb_tx_byte_sequencer;

   localparam int C = 4;

   logic       i_clk;
   logic       i_n_rst;
   logic       i_tx_start;
   logic       i_abort;
   logic       i_byte_valid;
   logic [7:0] i_byte_data;
   logic       i_byte_last;
   logic       o_byte_ready;
   logic       o_serial_out;
   logic       o_bit_strobe;
   logic       o_tx_active;
   logic       o_tx_done;
   logic       o_tx_error;

   tx_byte_sequencer #(.CLKS_PER_BIT(C)) dut (
      .i_clk        (i_clk),
      .i_n_rst      (i_n_rst),
      .i_tx_start   (i_tx_start),
      .i_abort      (i_abort),
      .i_byte_valid (i_byte_valid),
      .i_byte_data  (i_byte_data),
      .i_byte_last  (i_byte_last),
      .o_byte_ready (o_byte_ready),
      .o_serial_out (o_serial_out),
      .o_bit_strobe (o_bit_strobe),
      .o_tx_active  (o_tx_active),
      .o_tx_done    (o_tx_done),
      .o_tx_error   (o_tx_error)
   );

   int vectors = 0;
   int miscompares = 0;

   int exp_bits[$];   // expected serial bits, in line order
   int exp_done[$];   // expected tx_error value at each tx_done pulse

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   function automatic void chk(input string nm, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endfunction

   // ---------------- monitor ----------------
   initial begin
      int cyc = 0;
      int prev_strobe = 0;
      bit have_prev = 0;
      int zeros = 0;
      int ones = 0;
      int hist[$];
      forever begin
         @(negedge i_clk);
         cyc++;
         if (!i_n_rst || !o_tx_active) have_prev = 0;
         hist.push_back(int'(o_serial_out));
         if (hist.size() > C) void'(hist.pop_front());
         if (i_n_rst && o_bit_strobe) begin
            if (exp_bits.size() == 0) begin
               chk("unexpected_bit", 1, 0);
            end else begin
               int e;
               int held;
               e = exp_bits.pop_front();
               held = (hist.size() == C) ? 1 : 0;
               foreach (hist[k]) if (hist[k] != e) held = 0;
               chk("bit_value", int'(o_serial_out), e);
               chk("bit_period", held, 1);
            end
            if (have_prev) chk("bit_spacing", cyc - prev_strobe, C);
            prev_strobe = cyc;
            have_prev = 1;
            zeros = 0;
            ones = 0;
         end else if (i_n_rst && o_tx_active) begin
            if (o_serial_out) ones++;
            else zeros++;
         end
         if (i_n_rst && o_tx_done) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               int e;
               e = exp_done.pop_front();
               chk("done_error_flag", int'(o_tx_error), e);
               chk("eop_low_cycles", zeros, 2 * C);
               chk("eop_high_cycles", ones, C);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) exp_bits.push_back(int'(b[i]));
   endtask

   task automatic start_pkt();
      i_tx_start = 1'b1;
      @(negedge i_clk);
      i_tx_start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input logic l);
      int t = 0;
      i_byte_valid = 1'b1;
      i_byte_data  = d;
      i_byte_last  = l;
      while (!o_byte_ready && t < 400) begin
         @(negedge i_clk);
         t++;
      end
      if (t >= 400) chk("accept_timeout", 0, 1);
      @(negedge i_clk);
      i_byte_valid = 1'b0;
      chk("ready_low_after_accept", int'(o_byte_ready), 0);
   endtask

   task automatic wait_strobes(input int n);
      int seen = 0;
      int t = 0;
      while (t < 1000) begin
         if (o_bit_strobe) begin
            seen++;
            if (seen == n) break;
         end
         @(negedge i_clk);
         t++;
      end
      if (seen != n) chk("strobe_timeout", seen, n);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (o_tx_active && t < 3000) begin
         @(negedge i_clk);
         t++;
      end
      if (t >= 3000) chk("idle_timeout", 0, 1);
      @(negedge i_clk);
   endtask

   // Model: every offered byte goes out LSB-first; the packet ends in EOP
   // with tx_error set only when the byte stream stops without a last flag.
   task automatic run_packet(input logic [31:0] bytes, input int n,
                             input bit underrun, input int gapmax);
      for (int i = 0; i < n; i++) push_byte(bytes[8*i +: 8]);
      exp_done.push_back(underrun ? 1 : 0);
      start_pkt();
      repeat ($urandom_range(0, 5)) @(negedge i_clk);
      for (int i = 0; i < n; i++) begin
         send_byte(bytes[8*i +: 8], (!underrun && i == n - 1));
         if (i < n - 1) repeat ($urandom_range(0, gapmax)) @(negedge i_clk);
      end
      wait_idle();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      i_n_rst      = 1'b0;
      i_tx_start   = 1'b0;
      i_abort      = 1'b0;
      i_byte_valid = 1'b0;
      i_byte_data  = 8'h00;
      i_byte_last  = 1'b0;
      repeat (3) @(negedge i_clk);
      i_n_rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         chk("idle_serial", int'(o_serial_out), 1);
         chk("idle_ready", int'(o_byte_ready), 0);
         chk("idle_active", int'(o_tx_active), 0);
         chk("idle_done", int'(o_tx_done), 0);
         chk("idle_error", int'(o_tx_error), 0);
      end

      // Single last byte.
      run_packet(32'h0000_00A5, 1, 0, 0);

      // Two bytes offered early, must run back to back.
      run_packet(32'h0000_8001, 2, 0, 0);

      // Lone non-last byte: underrun, then next tx_start clears the flag.
      run_packet(32'h0000_003C, 1, 1, 0);
      chk("error_sticky", int'(o_tx_error), 1);
      push_byte(8'h5A);
      exp_done.push_back(0);
      start_pkt();
      chk("error_cleared_by_start", int'(o_tx_error), 0);
      send_byte(8'h5A, 1'b1);
      wait_idle();

      // Second byte shows up exactly on the boundary strobe: dropped.
      push_byte(8'h3C);
      exp_done.push_back(1);
      start_pkt();
      send_byte(8'h3C, 1'b0);
      wait_strobes(8);
      chk("ready_at_boundary", int'(o_byte_ready), 1);
      i_byte_valid = 1'b1;
      i_byte_data  = 8'hC3;
      i_byte_last  = 1'b1;
      @(negedge i_clk);
      i_byte_valid = 1'b0;
      wait_idle();

      // Abort during bit 3 of 0xFF: only bits 0..2 are seen, no done.
      for (int i = 0; i < 3; i++) exp_bits.push_back(1);
      start_pkt();
      send_byte(8'hFF, 1'b1);
      wait_strobes(3);
      @(negedge i_clk);
      i_abort = 1'b1;
      @(negedge i_clk);
      i_abort = 1'b0;
      chk("abort_serial", int'(o_serial_out), 1);
      chk("abort_active", int'(o_tx_active), 0);
      chk("abort_error", int'(o_tx_error), 0);
      repeat (4 * C) @(negedge i_clk);
      chk("abort_no_done_active", int'(o_tx_active), 0);

      // Random packets.
      for (int p = 0; p < 25; p++) begin
         int n;
         bit ur;
         n  = $urandom_range(1, 4);
         ur = ($urandom_range(0, 3) == 0);
         run_packet($urandom, n, ur, 10);
         repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end

      // Reset pulse in the middle of an underrun EOP.
      push_byte(8'h96);
      start_pkt();
      send_byte(8'h96, 1'b0);
      wait_strobes(8);
      repeat (5) @(negedge i_clk);
      chk("eop_error_before_reset", int'(o_tx_error), 1);
      chk("eop_serial_before_reset", int'(o_serial_out), 0);
      #2 i_n_rst = 1'b0;
      #1;
      chk("rst_serial", int'(o_serial_out), 1);
      chk("rst_ready", int'(o_byte_ready), 0);
      chk("rst_strobe", int'(o_bit_strobe), 0);
      chk("rst_active", int'(o_tx_active), 0);
      chk("rst_done", int'(o_tx_done), 0);
      chk("rst_error", int'(o_tx_error), 0);
      @(negedge i_clk);
      i_n_rst = 1'b1;
      repeat (4 * C) @(negedge i_clk);
      chk("post_rst_active", int'(o_tx_active), 0);

      chk("bits_outstanding", exp_bits.size(), 0);
      chk("done_outstanding", exp_done.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
